pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//  Parametrised program-counter generator for the RISC-V fetch stage; successor to the fixed-width +4 PC counter.
//  Adds a valid/ready fetch handshake, prioritised redirects (trap, branch/jump), halt/resume, alignment checking
//  and an accepted-fetch counter. Sits between the execute-stage redirect logic and the instruction memory port.
// PARAMETERS
//  WIDTH      32            PC width in bits
//  RESET_VEC  32'h0000_0000 PC value presented after reset
//  TRAP_VEC   32'h0000_0100 PC loaded on trap
//  CNT_WIDTH  16            width of fetch counter (saturating)
// PORTS
//  clk          in   1          clock, all state on rising edge
//  rst_n        in   1          asynchronous active-low reset
//  fetch_ready  in   1          imem accepts pc this cycle
//  redirect     in   1          branch/jump taken; load redirect_pc
//  redirect_pc  in   WIDTH      branch/jump target
//  trap         in   1          exception; load TRAP_VEC
//  halt_req     in   1          request halt (stop issuing fetches)
//  resume       in   1          leave HALT, continue at held pc
//  pc_is_c      in   1          current pc holds compressed instr (used only with PC_RVC_EN)
//  pc           out  WIDTH      current fetch address
//  pc_valid     out  1          pc is a valid fetch request
//  misalign     out  1          1-cycle pulse: redirect_pc misaligned
//  halted       out  1          block is in HALT
//  fetch_cnt    out  CNT_WIDTH  number of accepted fetches, saturates at all-ones
// BEHAVIOUR
//  Reset (async, rst_n=0): state=BOOT, pc=RESET_VEC, pc_valid=0, misalign=0, halted=0, fetch_cnt=0.
//  States: BOOT -> RUN unconditionally on first clk after reset release (pc_valid rises 1 cycle after rst_n=1).
//   RUN: pc_valid=1. HALT: pc_valid=0, halted=1, pc held.
//  Accept = pc_valid & fetch_ready. Next-pc priority, evaluated every cycle in RUN and HALT:
//   1 trap     -> pc=TRAP_VEC, state=RUN
//   2 redirect -> pc=aligned redirect_pc, state=RUN
//   3 halt_req (RUN only) -> state=HALT, pc unchanged (fetch accepted in same cycle still advances pc)
//   4 resume (HALT only) -> state=RUN, pc unchanged; resume ignored in RUN/BOOT
//   5 accept   -> pc=pc+INC; else pc held (stall: pc and pc_valid stable while !fetch_ready)
//  Trap/redirect in BOOT are ignored. Redirect during stall replaces pc; un-accepted old pc is dropped.
//  INC=4; pc+INC wraps modulo 2^WIDTH silently (0xFFFF_FFFC -> 0x0000_0000).
//  Alignment: redirect_pc low bits forced to zero before load; misalign=1 the cycle after load if cleared bits
//   were nonzero. Trap never sets misalign.
//  fetch_cnt increments on each accept, saturates; not cleared by trap/halt, only by reset.
//  Reset asserted mid-operation: all outputs to reset values immediately, in-flight request abandoned.
// CONFIGURATION
//  PC_RVC_EN defined: INC=2 when pc_is_c=1 else 4; alignment mask clears bit0 only (misalign if bit0=1).
//  PC_RVC_EN undefined: INC=4 always, pc_is_c ignored; mask clears bits[1:0] (misalign if either set).
// STRUCTURE
//  pc_pkg.vh (shared include): state encodings BOOT/RUN/HALT, INC_WORD=4, INC_HALF=2, align-mask macros.
//  Sub-module pc_next_mux: combinational priority select of next pc (trap/redirect/increment/hold) and
//   misalign detect; pc_gen holds state register, pc register, counter.
// TESTING
//  Reset release, fetch_ready=1 4 cycles -> pc_valid=0 first cycle, then pc=0x0,0x4,0x8,0xC.
//  fetch_ready=0 for 3 cycles at pc=0x8 -> pc stays 0x8, pc_valid=1, fetch_cnt unchanged.
//  redirect=1,redirect_pc=0x203 and trap=1 same cycle -> pc=0x100, misalign=0; then redirect 0x203 alone
//   -> pc=0x200, misalign pulse (0x202 and misalign with PC_RVC_EN).
//  halt_req at pc=0x10 with no accept -> halted=1, pc_valid=0, pc=0x10; resume -> pc_valid=1, pc=0x10.
//  pc=0xFFFF_FFFC accepted -> pc=0x0; CNT_WIDTH=4, 20 accepts -> fetch_cnt=0xF.
//  PC_RVC_EN: pc_is_c=1 at 0x0 then 0 at 0x2 -> pc=0x2, then 0x6; rst_n low mid-stall -> pc=RESET_VEC async.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: FSM state encoding, PC increments and alignment masks shared by pc_gen and its next-pc mux.
package pc_gen_pkg;
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
    localparam int INC_WORD       = 4;
    localparam int INC_HALF       = 2;
    localparam int ALIGN_MASK_RVC = 1;
    localparam int ALIGN_MASK_STD = 3;
endpackage

// File: rtl/pc_gen_next_mux.sv
// pc_gen_next_mux: prioritised next-pc select (trap > redirect > increment > hold) and misalign detect.
// Optional PC_RVC_EN: half-word increments for compressed instructions and bit0-only alignment.
module pc_gen_next_mux
    import pc_gen_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic             i_active,
    input  logic             i_trap,
    input  logic             i_redirect,
    input  logic [WIDTH-1:0] i_redirect_pc,
    input  logic             i_accept,
    input  logic             i_pc_is_c,
    input  logic [WIDTH-1:0] i_pc,
    output logic [WIDTH-1:0] o_next_pc,
    output logic             o_misalign
);
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_mask;
`ifdef PC_RVC_EN
    assign w_inc  = i_pc_is_c ? WIDTH'(INC_HALF) : WIDTH'(INC_WORD);
    assign w_mask = WIDTH'(ALIGN_MASK_RVC);
`else
    logic w_unused;
    assign w_unused = i_pc_is_c;
    assign w_inc    = WIDTH'(INC_WORD);
    assign w_mask   = WIDTH'(ALIGN_MASK_STD);
`endif
    // BOOT (inactive) ignores trap/redirect entirely; accept is already gated by pc_valid
    assign o_next_pc  = !i_active  ? i_pc :
                        i_trap     ? TRAP_VEC :
                        i_redirect ? (i_redirect_pc & ~w_mask) :
                        i_accept   ? i_pc + w_inc : i_pc;
    assign o_misalign = i_active & ~i_trap & i_redirect & (|(i_redirect_pc & w_mask));
endmodule

// File: rtl/pc_gen.sv
// pc_gen: RISC-V fetch PC generator with handshake, trap/redirect priority, halt/resume and saturating fetch counter.
// Optional PC_RVC_EN enables compressed-instruction increments and half-word alignment.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_0000,
    parameter logic [WIDTH-1:0] TRAP_VEC  = 32'h0000_0100,
    parameter int               CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fetch_ready,
    input  logic                 redirect,
    input  logic [WIDTH-1:0]     redirect_pc,
    input  logic                 trap,
    input  logic                 halt_req,
    input  logic                 resume,
    input  logic                 pc_is_c,
    output logic [WIDTH-1:0]     pc,
    output logic                 pc_valid,
    output logic                 misalign,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] fetch_cnt
);
    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_pc;
    logic [WIDTH-1:0]     w_next_pc;
    logic                 r_misalign;
    logic                 w_misalign;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 w_accept;

    assign pc_valid  = (r_state == RUN);
    assign halted    = (r_state == HALT);
    assign pc        = r_pc;
    assign misalign  = r_misalign;
    assign fetch_cnt = r_cnt;
    assign w_accept  = pc_valid & fetch_ready;

    pc_gen_next_mux #(.WIDTH(WIDTH), .TRAP_VEC(TRAP_VEC)) u_next_mux (
        .i_active      (r_state != BOOT),
        .i_trap        (trap),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .i_accept      (w_accept),
        .i_pc_is_c     (pc_is_c),
        .i_pc          (r_pc),
        .o_next_pc     (w_next_pc),
        .o_misalign    (w_misalign)
    );

    always_comb begin
        w_state_nxt = (r_state == BOOT || trap || redirect) ? RUN :
                      (r_state == RUN  && halt_req)         ? HALT :
                      (r_state == HALT && resume)           ? RUN : r_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= BOOT;
            r_pc       <= RESET_VEC;
            r_misalign <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_next_pc;
            r_misalign <= w_misalign;
            if (w_accept && !(&r_cnt))
                r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: randomized scoreboard bench for pc_gen; stimulus pushes model expectations, a monitor pops and compares.
// Follows PC_RVC_EN the same way the design does.
module tb_pc_gen;
    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
    localparam int          CNT_MAX   = 15;

    typedef struct {
        logic [31:0] pc;
        logic        v;
        logic        h;
        logic        m;
        logic [3:0]  cnt;
    } exp_t;

    logic        clk, rst_n, fetch_ready, redirect, trap, halt_req, resume, pc_is_c;
    logic [31:0] redirect_pc, pc;
    logic        pc_valid, misalign, halted;
    logic [3:0]  fetch_cnt;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    bit          m_boot = 1, m_halt = 0, m_mis = 0;
    logic [31:0] m_pc = RESET_VEC;
    int          m_cnt = 0;

    pc_gen #(.CNT_WIDTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_ready (fetch_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .trap        (trap),
        .halt_req    (halt_req),
        .resume      (resume),
        .pc_is_c     (pc_is_c),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .misalign    (misalign),
        .halted      (halted),
        .fetch_cnt   (fetch_cnt)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        n_chk++;
        if (a !== x) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, x, $time);
        end
    endtask

    task automatic model_reset();
        m_boot = 1; m_halt = 0; m_mis = 0; m_pc = RESET_VEC; m_cnt = 0;
    endtask

    // Behavioural model: the architectural effect of one clock edge given this cycle's inputs
    task automatic step(input bit fr, input bit rd, input logic [31:0] rpc, input bit tr,
                        input bit hr, input bit rs, input bit c, input bit rn);
        bit   acc;
        int   align, inc;
        exp_t e;
        @(negedge clk);
        rst_n = rn; fetch_ready = fr; redirect = rd; redirect_pc = rpc;
        trap = tr; halt_req = hr; resume = rs; pc_is_c = c;
`ifdef PC_RVC_EN
        align = 2;
        inc   = c ? 2 : 4;
`else
        align = 4;
        inc   = 4;
`endif
        acc = !m_boot && !m_halt && fr;
        if (!rn) model_reset();
        else if (m_boot) begin
            m_boot = 0;
            m_mis  = 0;
        end else begin
            m_mis = 0;
            if (tr) begin
                m_pc = TRAP_VEC; m_halt = 0;
            end else if (rd) begin
                m_mis  = (rpc % align) != 0;
                m_pc   = rpc - (rpc % align);
                m_halt = 0;
            end else begin
                if (!m_halt && hr) m_halt = 1;
                else if (m_halt && rs) m_halt = 0;
                if (acc) m_pc = m_pc + inc;
            end
            if (acc && m_cnt < CNT_MAX) m_cnt++;
        end
        e.pc = m_pc; e.v = !m_boot && !m_halt; e.h = m_halt; e.m = m_mis; e.cnt = 4'(m_cnt);
        q.push_back(e);
    endtask

    task automatic idle(input bit fr);
        step(fr, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc", pc, e.pc);
                chk("pc_valid", 32'(pc_valid), 32'(e.v));
                chk("halted", 32'(halted), 32'(e.h));
                chk("misalign", 32'(misalign), 32'(e.m));
                chk("fetch_cnt", 32'(fetch_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin : stim
        rst_n = 0; fetch_ready = 0; redirect = 0; redirect_pc = 0;
        trap = 0; halt_req = 0; resume = 0; pc_is_c = 0;
        #1;
        chk("reset_pc", pc, RESET_VEC);
        chk("reset_valid", 32'(pc_valid), 0);
        chk("reset_cnt", 32'(fetch_cnt), 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) idle(1);
        repeat (3) idle(0);
        step(1, 1, 32'h203, 1, 0, 0, 0, 1);
        step(0, 1, 32'h203, 0, 0, 0, 0, 1);
        idle(0);
        step(0, 1, 32'h10, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1, 0, 1);
        idle(0);
        step(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 1);
        idle(1);
        idle(0);
        step(1, 0, 0, 0, 1, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 0, 1);
        repeat (20) idle(1);
`ifdef PC_RVC_EN
        step(0, 0, 0, 0, 0, 0, 0, 0);
        idle(0);
        step(1, 0, 0, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1);
`endif
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 32'h3FF));
            step($urandom_range(0, 9) < 7, $urandom_range(0, 7) == 0, rpc,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 199) != 0);
        end
        step(0, 1, 32'h40, 0, 0, 0, 0, 1);
        repeat (2) idle(0);
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        chk("async_pc", pc, RESET_VEC);
        chk("async_valid", 32'(pc_valid), 0);
        chk("async_cnt", 32'(fetch_cnt), 0);
        model_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) idle(1);
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        #2;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
